// File: rtl/yarvi_uart.sv
// 8N1 UART bridging board serial pins to the SoC byte handshake.
// Fixed bit divisor; received bytes are buffered in a small FIFO.
module yarvi_uart #(
  parameter int CLK_PER_BIT  = 16,
  parameter int RX_FIFO_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int PW    = RX_FIFO_LOG2;
  localparam int DEPTH = 1 << RX_FIFO_LOG2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = BIT_LAST;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign uart_tx  = tx_line_q;

  // ---------------- receiver ----------------
  logic            sync1_q, rxs_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_push;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rxs_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rxs_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      // Held-low line: stay here until it idles so only one error is reported.
      RX_BREAK: begin
        if (rxs_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= uart_rx;
      rxs_q       <= sync1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_frame_err = frame_err_q;

  // ---------------- RX FIFO ----------------
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          fifo_full, fifo_pop, fifo_accept;

  assign fifo_full = (count_q == FULL_CNT);
  assign fifo_pop  = rx_valid && rx_ready;
  // A full FIFO still takes the byte when the head is leaving this cycle.
  assign fifo_accept = rx_push && (!fifo_full || fifo_pop);

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    overrun_d = rx_push && fifo_full && !fifo_pop;
    if (fifo_accept) begin
      mem_d[tail_q] = rx_shift_q;
      tail_d        = tail_q + PW'(1);
    end
    if (fifo_pop) head_d = head_q + PW'(1);
    case ({fifo_accept, fifo_pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q     <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = mem_q[head_q];
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_yarvi_uart.sv
// Scoreboard bench for yarvi_uart: directed serial frames, TX waveform check, loopback.
module tb_yarvi_uart;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       uart_rx;
  logic       uart_tx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  yarvi_uart #(.CLK_PER_BIT(CPB), .RX_FIFO_LOG2(2)) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int valid_cycles = 0;
  int unsigned last_pop_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed byte is matched against the scoreboard queue.
  always @(negedge clock) begin
    if (reset) begin
      if (rx_frame_err) ferr_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) begin
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte 0x%0h with nothing expected", rx_data);
        end else begin
          chk("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
    @(posedge clock); #1;
    t0 = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic tx_send(input logic [7:0] b);
    bit acc = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(negedge clock);
      if (tx_ready) begin
        @(posedge clock);
        acc = 1;
      end
    end
    #1;
    tx_valid = 1'b0;
    if (!acc) chk("tx_accept_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [9:0]  frame;
    int          ok, low, f0, v0, o0;
    int unsigned t0;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_frame_err", 32'(rx_frame_err), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // TX waveform for 0x55; tx_data changes while busy are ignored
    repeat (2) @(posedge clock); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(posedge clock); #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    frame = {1'b1, 8'h55, 1'b0};
    low = 0;
    for (int b = 0; b < 10; b++) begin
      ok = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        if (uart_tx === frame[b]) ok++;
        if (tx_ready === 1'b0) low++;
      end
      chk($sformatf("tx_bit%0d_cycles", b), ok, CPB);
    end
    @(negedge clock);
    chk("tx_ready_low_cycles", low, 10 * CPB);
    chk("tx_ready_after", 32'(tx_ready), 1);
    chk("tx_idle_line", 32'(uart_tx), 1);

    // Single byte 0xA3 with latency bound
    rx_ready = 1'b1;
    f0 = ferr_cnt; v0 = valid_cycles;
    exp_q.push_back(8'hA3);
    rx_frame(8'hA3, 1'b1, t0);
    hold(1'b1, 2 * CPB);
    chk("a3_received", exp_q.size(), 0);
    chk("a3_latency_ok", 32'((last_pop_cyc - t0) <= 154), 1);
    chk("a3_valid_one_cycle", valid_cycles - v0, 1);
    chk("a3_no_frame_err", ferr_cnt - f0, 0);

    // Glitch shorter than half a bit
    f0 = ferr_cnt; v0 = valid_cycles;
    hold(1'b0, 4);
    hold(1'b1, 3 * CPB);
    chk("glitch_no_byte", valid_cycles - v0, 0);
    chk("glitch_no_err", ferr_cnt - f0, 0);

    // Stop bit low, line held low 100 bit times, then a good 0x3C
    f0 = ferr_cnt; v0 = valid_cycles;
    rx_frame(8'h99, 1'b0, t0);
    hold(1'b0, 100 * CPB);
    hold(1'b1, 2 * CPB);
    chk("break_one_frame_err", ferr_cnt - f0, 1);
    chk("break_no_byte", valid_cycles - v0, 0);
    exp_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1, t0);
    hold(1'b1, 2 * CPB);
    chk("after_break_3c", exp_q.size(), 0);

    // Overrun: four buffered, fifth dropped
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) begin
      rx_frame(8'(i), 1'b1, t0);
      hold(1'b1, 2 * CPB);
    end
    @(negedge clock);
    chk("overrun_once", ovr_cnt - o0, 1);
    chk("fifo_head_valid", 32'(rx_valid), 1);
    chk("fifo_head_data", 32'(rx_data), 32'h01);
    @(posedge clock); #1;
    rx_ready = 1'b1;
    drain(20);
    @(negedge clock);
    chk("fifo_empty_after_drain", 32'(rx_valid), 0);

    // Full-duplex loopback
    @(posedge clock); #1;
    loop_en = 1'b1;
    f0 = ferr_cnt;
    exp_q.push_back(8'h00); tx_send(8'h00);
    exp_q.push_back(8'hFF); tx_send(8'hFF);
    exp_q.push_back(8'h80); tx_send(8'h80);
    drain(2000);
    chk("loop_no_frame_err", ferr_cnt - f0, 0);

    // Reset mid-frame
    repeat (4 * CPB) @(posedge clock); #1;
    v0 = valid_cycles;
    tx_send(8'h5A);
    repeat (60) @(posedge clock); #1;
    reset = 1'b0;
    #2;
    chk("midrst_uart_tx", 32'(uart_tx), 1);
    chk("midrst_tx_ready", 32'(tx_ready), 1);
    chk("midrst_rx_valid", 32'(rx_valid), 0);
    chk("midrst_rx_data", 32'(rx_data), 0);
    chk("midrst_frame_err", 32'(rx_frame_err), 0);
    chk("midrst_overrun", 32'(rx_overrun), 0);
    repeat (3) @(posedge clock); #1;
    reset = 1'b1;
    repeat (400) @(posedge clock);
    @(negedge clock);
    chk("midrst_no_byte", valid_cycles - v0, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
